// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the Wishbone register file slave: map, bit fields, bus FSM.
package wb_regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADR_W  = 10;
  localparam int unsigned SEL_W  = DATA_W / 8;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned INT_W  = 2;

  // Register word addresses
  localparam logic [ADR_W-1:0] ADR_CTRL     = 10'h000;
  localparam logic [ADR_W-1:0] ADR_PERIOD   = 10'h001;
  localparam logic [ADR_W-1:0] ADR_COUNT    = 10'h002;
  localparam logic [ADR_W-1:0] ADR_INT_SRC  = 10'h003;
  localparam logic [ADR_W-1:0] ADR_INT_MASK = 10'h004;
  localparam logic [ADR_W-1:0] ADR_SCRATCH  = 10'h005;

  // CTRL bit indices
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_RELOAD = 1;

  // INT_SRC / INT_MASK bit indices
  localparam int unsigned INT_TIMER  = 0;
  localparam int unsigned INT_BUSERR = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

  // Expand byte-lane enables into a bit mask
  function automatic logic [DATA_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(SEL_W); i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_timer_core.sv
// Programmable interval timer: counts 0..period, flags expiry, requests EN clear when not reloading.
module wb_timer_core
  import wb_regfile_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              reload_i,
  input  logic [DATA_W-1:0] period_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] count_o,
  output logic              expire_c_o,
  output logic              clr_en_c_o
);

  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] count_d;

  // Expiry detection and next count; an EN 0->1 clear takes priority
  always_comb begin
    count_d    = count_q;
    expire_c_o = en_i && (period_i != '0) && (count_q == period_i);
    clr_en_c_o = expire_c_o && !reload_i;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (period_i == '0 || expire_c_o) begin
        count_d = '0;
      end else begin
        count_d = count_q + DATA_W'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone slave register file with interval timer and maskable interrupt.
module wb_regfile_slave
  import wb_regfile_pkg::*;
#(
  parameter logic [31:0] PERIOD_RST  = 32'h0000_0000,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [11:2]       wb_adr_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              int_o
);

  bus_state_e        state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              int_q, int_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] period_q, period_d;
  logic [INT_W-1:0]  int_src_q, int_src_d;
  logic [INT_W-1:0]  int_mask_q, int_mask_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;

  logic [DATA_W-1:0] mask;
  logic [INT_W-1:0]  int_src_set;
  logic [INT_W-1:0]  int_src_clr;
  logic              ctrl_wr;
  logic              bad_acc;
  logic              tmr_clr;
  logic [DATA_W-1:0] tmr_count;
  logic              tmr_expire;
  logic              tmr_clr_en;

  wb_timer_core u_timer (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_i),
    .en_i       (ctrl_q[CTRL_EN]),
    .reload_i   (ctrl_q[CTRL_RELOAD]),
    .period_i   (period_q),
    .clr_i      (tmr_clr),
    .count_o    (tmr_count),
    .expire_c_o (tmr_expire),
    .clr_en_c_o (tmr_clr_en)
  );

  // Bus FSM, address decode, register writes, read capture and interrupt sources
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    dat_d       = '0;
    ctrl_d      = ctrl_q;
    period_d    = period_q;
    int_mask_d  = int_mask_q;
    scratch_d   = scratch_q;
    int_src_set = '0;
    int_src_clr = '0;
    ctrl_wr     = 1'b0;
    bad_acc     = 1'b0;
    tmr_clr     = 1'b0;
    mask        = lane_mask(wb_sel_i);

    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d = ST_RESP;
          bad_acc = (wb_adr_i > ADR_SCRATCH) || (wb_we_i && (wb_adr_i == ADR_COUNT));
          if (bad_acc) begin
            err_d                   = 1'b1;
            int_src_set[INT_BUSERR] = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (wb_we_i) begin
              case (wb_adr_i)
                ADR_CTRL: begin
                  ctrl_wr = 1'b1;
                  ctrl_d  = (ctrl_q & ~mask[CTRL_W-1:0]) | (wb_dat_i[CTRL_W-1:0] & mask[CTRL_W-1:0]);
                end
                ADR_PERIOD:   period_d    = (period_q & ~mask) | (wb_dat_i & mask);
                ADR_INT_SRC:  int_src_clr = wb_dat_i[INT_W-1:0] & mask[INT_W-1:0];
                ADR_INT_MASK: int_mask_d  = (int_mask_q & ~mask[INT_W-1:0]) |
                                            (wb_dat_i[INT_W-1:0] & mask[INT_W-1:0]);
                ADR_SCRATCH:  scratch_d   = (scratch_q & ~mask) | (wb_dat_i & mask);
                default: ;
              endcase
            end else begin
              case (wb_adr_i)
                ADR_CTRL:     dat_d = DATA_W'(ctrl_q);
                ADR_PERIOD:   dat_d = period_q;
                ADR_COUNT:    dat_d = tmr_count;
                ADR_INT_SRC:  dat_d = DATA_W'(int_src_q);
                ADR_INT_MASK: dat_d = DATA_W'(int_mask_q);
                ADR_SCRATCH:  dat_d = scratch_q;
                default:      dat_d = '0;
              endcase
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Software CTRL write beats the timer's auto-clear of EN
    tmr_clr = ctrl_wr && ctrl_d[CTRL_EN] && !ctrl_q[CTRL_EN];
    if (!ctrl_wr && tmr_clr_en) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end

    // Hardware set wins over a simultaneous W1C
    int_src_set[INT_TIMER] = tmr_expire;
    int_src_d = (int_src_q & ~int_src_clr) | int_src_set;
    int_d     = |(int_src_q & int_mask_q);
  end

  // State and register bank
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      int_q      <= 1'b0;
      ctrl_q     <= '0;
      period_q   <= PERIOD_RST;
      int_src_q  <= '0;
      int_mask_q <= '0;
      scratch_q  <= SCRATCH_RST;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      int_q      <= int_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      int_src_q  <= int_src_d;
      int_mask_q <= int_mask_d;
      scratch_q  <= scratch_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign int_o    = int_q;

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Directed bench for wb_regfile_slave with an expected-response scoreboard.
module tb_wb_regfile_slave;
  import wb_regfile_pkg::*;

  localparam logic [31:0] P_RST = 32'h0000_0010;
  localparam logic [31:0] S_RST = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:2] adr;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] dat_w, dat_r;
  logic        ack, err, irq;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int last_edge = 0;
  logic int_at_ack;

  typedef struct {
    string       tag;
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  wb_regfile_slave #(.PERIOD_RST(P_RST), .SCRATCH_RST(S_RST)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_dat_i (dat_w),
    .wb_dat_o (dat_r),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .int_o    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Position so the next bus request is sampled at edge t
  task automatic goto_edge(input int t);
    while (cyc_cnt < t - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus access; response checked 1 cycle after the sampling edge, then pulse end
  task automatic bus(input logic w, input logic [9:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic e_ack, input logic e_err,
                     input logic [31:0] e_dat, input string tag);
    exp_t e, got;
    e.tag = tag; e.ack = e_ack; e.err = e_err; e.dat = e_dat;
    sb.push_back(e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    @(posedge clk);
    #1;
    last_edge = cyc_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_w = '0;
    int_at_ack = irq;
    got = sb.pop_front();
    chk({got.tag, ".ack"}, 32'(ack), 32'(got.ack));
    chk({got.tag, ".err"}, 32'(err), 32'(got.err));
    chk({got.tag, ".dat"}, dat_r, got.dat);
    @(posedge clk);
    #1;
    chk({got.tag, ".pulse_end"}, 32'({ack, err}), 32'h0);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e_dat, input string tag);
    bus(1'b0, a, 4'hF, 32'h0, 1'b1, 1'b0, e_dat, tag);
  endtask

  task automatic wr(input logic [9:0] a, input logic [3:0] s, input logic [31:0] d, input string tag);
    bus(1'b1, a, s, d, 1'b1, 1'b0, 32'h0, tag);
  endtask

  int e0, f0, g0;

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat_w = '0;
    #1;
    chk("rst.outs", {dat_r[28:0], ack, err, irq}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset values of every mapped register
    rd(ADR_CTRL,     32'h0, "rv_ctrl");
    rd(ADR_PERIOD,   P_RST, "rv_period");
    rd(ADR_COUNT,    32'h0, "rv_count");
    rd(ADR_INT_SRC,  32'h0, "rv_int_src");
    rd(ADR_INT_MASK, 32'h0, "rv_int_mask");
    rd(ADR_SCRATCH,  S_RST, "rv_scratch");
    chk("rv_int", 32'(irq), 32'h0);

    // Byte-lane writes and sel=0 no-op
    wr(ADR_SCRATCH, 4'hF, 32'hDEAD_BEEF, "wr_scr_full");
    wr(ADR_SCRATCH, 4'b0101, 32'h1122_3344, "wr_scr_lanes");
    rd(ADR_SCRATCH, 32'hDE22_BE44, "rd_scr_lanes");
    wr(ADR_SCRATCH, 4'h0, 32'hFFFF_FFFF, "wr_scr_sel0");
    rd(ADR_SCRATCH, 32'hDE22_BE44, "rd_scr_sel0");

    // Error terminations
    wr(ADR_INT_MASK, 4'hF, 32'h2, "wr_mask2");
    bus(1'b0, 10'h3FF, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, "err_unmapped");
    chk("err_int_delay", 32'(int_at_ack), 32'h0);
    chk("err_int_rise", 32'(irq), 32'h1);
    bus(1'b1, ADR_COUNT, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 32'h0, "err_wr_count");
    rd(ADR_COUNT, 32'h0, "rd_count_unchanged");
    rd(ADR_INT_SRC, 32'h2, "rd_int_src_err");
    wr(ADR_INT_SRC, 4'hF, 32'h2, "w1c_buserr");
    rd(ADR_INT_SRC, 32'h0, "rd_int_src_clr");

    // Timer with auto-reload
    wr(ADR_PERIOD, 4'hF, 32'h3, "wr_period3");
    wr(ADR_INT_MASK, 4'hF, 32'h1, "wr_mask1");
    wr(ADR_CTRL, 4'hF, 32'h3, "wr_ctrl_en_rl");
    e0 = last_edge;
    rd(ADR_COUNT, 32'h1, "tmr_cnt_e2");
    rd(ADR_COUNT, 32'h3, "tmr_cnt_e4");
    chk("tmr_int_e4", 32'(int_at_ack), 32'h0);
    chk("tmr_int_e5", 32'(irq), 32'h1);
    rd(ADR_INT_SRC, 32'h1, "tmr_src_e6");
    rd(ADR_COUNT, 32'h3, "tmr_cnt_e8");
    rd(ADR_COUNT, 32'h1, "tmr_cnt_e10");

    // W1C colliding with expiry at e0+12, then a clean W1C at e0+17
    goto_edge(e0 + 12);
    wr(ADR_INT_SRC, 4'hF, 32'h1, "w1c_collide");
    rd(ADR_INT_SRC, 32'h1, "src_after_collide");
    goto_edge(e0 + 17);
    wr(ADR_INT_SRC, 4'hF, 32'h1, "w1c_clean");
    chk("w1c_int_hold", 32'(int_at_ack), 32'h1);
    chk("w1c_int_fall", 32'(irq), 32'h0);
    rd(ADR_INT_SRC, 32'h0, "src_after_clean");

    // One-shot mode: EN self-clears after the first expiry
    wr(ADR_CTRL, 4'hF, 32'h0, "wr_ctrl_stop");
    wr(ADR_INT_SRC, 4'hF, 32'h3, "w1c_all");
    wr(ADR_CTRL, 4'hF, 32'h1, "wr_ctrl_oneshot");
    f0 = last_edge;
    rd(ADR_CTRL, 32'h1, "os_ctrl_f2");
    rd(ADR_COUNT, 32'h3, "os_cnt_f4");
    rd(ADR_CTRL, 32'h0, "os_ctrl_f6");
    rd(ADR_COUNT, 32'h0, "os_cnt_f8");
    rd(ADR_INT_SRC, 32'h1, "os_src");

    // Reset during RESP while the timer runs
    wr(ADR_CTRL, 4'hF, 32'h3, "wr_ctrl_run");
    g0 = last_edge;
    goto_edge(g0 + 7);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ADR_SCRATCH; sel = 4'hF;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    chk("mid_pre_ack", 32'(ack), 32'h1);
    chk("mid_pre_int", 32'(irq), 32'h1);
    chk("mid_pre_cnt", dut.u_timer.count_q, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {dat_r[28:0], ack, err, irq}, 32'h0);
    chk("mid_rst_cnt", dut.u_timer.count_q, 32'h0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    chk("mid_rst_noack", 32'({ack, err}), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    rd(ADR_CTRL, 32'h0, "post_ctrl");
    rd(ADR_SCRATCH, S_RST, "post_scratch");
    rd(ADR_COUNT, 32'h0, "post_count");
    rd(ADR_INT_SRC, 32'h0, "post_int_src");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile_slave.md
# wb_regfile_slave

Wishbone slave register file that terminates the processor-side Wishbone bus: it decodes `wb_adr_i`, writes and reads a small bank of 32-bit control and status registers, and produces the `wb_ack_o`, `wb_err_o`, `wb_dat_o` and `int_o` responses. It contains a programmable interval timer and a maskable interrupt controller, so the bus monitor sees real acknowledge, error and interrupt traffic.

## Interface
- `PERIOD_RST`, default 32'h0000_0000: reset value of the PERIOD register.
- `SCRATCH_RST`, default 32'h0000_0000: reset value of the SCRATCH register.
- Clock and reset: one clock, `wb_clk_i`. Reset `wb_rst_i` is asynchronous and active-low, despite the `_i` naming.

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: asynchronous active-low reset.
- `wb_adr_i` in [11:2]: word address; byte offset is implicitly 00.
- `wb_sel_i` in 4: byte lane enables.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: normal termination.
- `wb_err_o` out 1: error termination.
- `int_o` out 1: interrupt, level, active-high.

## Operation
Register map (word address):
- 0x000 CTRL, RW. Bit 0 EN (timer enable), bit 1 RELOAD (auto-reload). Other bits read 0.
- 0x001 PERIOD, RW, 32 bits.
- 0x002 COUNT, RO. Current timer count.
- 0x003 INT_SRC, W1C. Bit 0 timer expiry, bit 1 bus error.
- 0x004 INT_MASK, RW, bits [1:0].
- 0x005 SCRATCH, RW, 32 bits.

Error and write rules:
- Any other address, or a write to COUNT, terminates with `wb_err_o`. No register changes, except that INT_SRC[1] is set.
- Writes honour `wb_sel_i` per byte lane on RW registers.
- `wb_sel_i`=0 is a legal no-op access: it gets ack and writes nothing.

Bus FSM, states IDLE and RESP:
- IDLE→RESP when `wb_cyc_i & wb_stb_i`. The decode, the register write and the read-data capture happen on that same edge.
- RESP asserts exactly one of ack or err for one cycle, then goes to IDLE unconditionally.
- Requests are ignored while in RESP.

Timer:
- When EN=1 and PERIOD≠0, COUNT increments by 1 each cycle.
- When COUNT==PERIOD:
  - the next edge sets INT_SRC[0];
  - COUNT becomes 0;
  - if RELOAD=0, EN clears.
- PERIOD=0 means COUNT holds at 0 and no event is generated.
- A CTRL write that takes EN from 0→1 clears COUNT to 0.
- The counter wraps modulo 2^32.

Interrupt:
- `int_o` is the registered value of `|(INT_SRC & INT_MASK)`.

## Timing
- Reset values:
  - All registers take their parameter value or 0.
  - FSM is in IDLE.
  - `wb_ack_o`, `wb_err_o`, `int_o` are 0.
  - `wb_dat_o` is 0.
- Access latency: a request sampled at edge N gives ack or err high during cycle N+1, as a single-cycle pulse. The earliest next request is sampled at N+2.
- `wb_dat_o` is valid only while `wb_ack_o` is high on a read. It is 0 on err, on writes, and otherwise.
- Write visibility: a register written at edge N reads the new value in a request sampled at N+2.
- Simultaneous hardware set and software W1C of the same INT_SRC bit: the set wins.
- Simultaneous CTRL write and timer event: the software write to EN wins, and INT_SRC[0] is still set.
- `int_o` follows INT_SRC/INT_MASK with 1 cycle of delay.
- Reset asserted mid-transaction: outputs clear immediately (asynchronously). The pending request is dropped with no ack.

## Structure
- Shared package `wb_regfile_pkg`:
  - register word-address localparams;
  - CTRL and INT_SRC bit indices;
  - the bus FSM enum (IDLE, RESP).
- One sub-module, `wb_timer_core`:
  - inputs: enable, reload, period, and the clear-on-enable strobe;
  - outputs: count, expiry pulse, and the auto-clear-EN request.
- Decode, register bank and interrupt logic stay in the top module.

## Test plan
- Reset value check:
  - Release reset and read every mapped address.
  - Expected: CTRL, COUNT, INT_SRC and INT_MASK read 0; PERIOD and SCRATCH read their parameter values; `int_o`=0.
  - Each ack arrives exactly 1 cycle after its strobe.
- Byte-lane write:
  - Write SCRATCH=0xDEADBEEF with sel=4'hF.
  - Then write 0x11223344 with sel=4'b0101.
  - Read back. Expected: 0xDE22BE44.
- Unmapped address and COUNT write:
  - Access address 0x3FF, then write COUNT.
  - Expected: both terminate with `wb_err_o` and no ack; COUNT is unchanged; INT_SRC reads 0x2.
  - With INT_MASK=0x2, `int_o` rises 1 cycle after the INT_SRC set.
- Timer with auto-reload:
  - PERIOD=3, INT_MASK=1, CTRL=0x3, with the CTRL write landing at edge E.
  - Expected: COUNT=3 at E+3; INT_SRC[0] set at E+4 with COUNT=0; `int_o` high at E+5; expiry repeats every 4 cycles.
  - With RELOAD=0, EN reads 0 after the first expiry.
- W1C collision:
  - Write INT_SRC=0x1 on the same edge as a timer expiry.
  - Expected: INT_SRC[0] remains 1.
  - A later W1C with no expiry clears it, and `int_o` falls 1 cycle later.
- Reset mid-operation:
  - Assert `wb_rst_i` low during RESP while the timer is running.
  - Expected: ack, err, `int_o` and COUNT clear immediately, and the FSM returns to IDLE.
  - After release, the first access completes normally.
